nibble_seq_adder: RTL

NIBBLE_SEQ_ADDER -- requirements
Module: nibble_seq_adder

---
 rtl/nibble_seq_adder_pkg.sv | 11 +
 rtl/nibble_seq_adder_nibble_add.sv | 20 ++
 rtl/nibble_seq_adder.sv | 92 +++++++++
 3 files changed

// File: rtl/nibble_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_seq_adder_pkg;
  localparam int NIBBLE_W    = 4;
  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/nibble_seq_adder_nibble_add.sv
// Combinational 4-bit adder slice; also exposes the carry into the top bit for overflow.
module nibble_add
  import nibble_seq_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c_top
);
  logic [NIBBLE_W-2:0] low;
  logic                top;

  // Split at the top bit so its carry-in is visible.
  assign {c_top, low} = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
                      + {{(NIBBLE_W-1){1'b0}}, ci};
  assign {co, top}    = {1'b0, a[NIBBLE_W-1]} + {1'b0, b[NIBBLE_W-1]} + {1'b0, c_top};
  assign s            = {top, low};
endmodule

// File: rtl/nibble_seq_adder.sv
// Nibble-serial add/subtract: one 4-bit slice reused for NIBBLES cycles per operation.
module nibble_seq_adder
  import nibble_seq_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sub,
  input  logic                         cin,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         ovf
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t              state, state_nxt;
  logic [W-1:0]        a_q, b_q;
  logic                carry;
  logic [IDX_W-1:0]    idx;
  logic                accept;
  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                co_nib, ctop_nib;

  assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

  nibble_add u_add (
    .a     (a_nib),
    .b     (b_nib),
    .ci    (carry),
    .s     (s_nib),
    .co    (co_nib),
    .c_top (ctop_nib)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Subtraction is a + ~b + 1, so only b and the initial carry differ.
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= sub | cin;
        idx   <= '0;
      end else if (state == RUN) begin
        sum[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
        carry <= co_nib;
        if (idx == LAST) ovf <= ctop_nib ^ co_nib;
        else             idx <= idx + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign cout = carry;
endmodule
